// File: rtl/lsu_align_unit_pkg.sv
// Shared definitions for the load/store alignment unit: width codes,
// FSM state encoding and small decode helpers.
package lsu_pkg;

  // RISC-V load width codes
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // RISC-V store width codes
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    ACC1 = 2'd2,
    RESP = 2'd3
  } lsu_state_e;

  // Access size in bytes (1, 2 or 4); the upper func3 bit only selects
  // signedness, so the low two bits decide the width.
  function automatic logic [2:0] size_of(input logic [2:0] func3);
    logic [2:0] size;
    case (func3[1:0])
      2'b00:   size = 3'd1;
      2'b01:   size = 3'd2;
      default: size = 3'd4;
    endcase
    return size;
  endfunction

  // Loads accept the five RV32 widths, stores only the three plain ones.
  function automatic logic is_legal(input logic store, input logic [2:0] func3);
    logic legal;
    if (store) begin
      legal = (func3 == F3_SB) || (func3 == F3_SH) || (func3 == F3_SW);
    end else begin
      legal = (func3 == F3_LB) || (func3 == F3_LH) || (func3 == F3_LW) ||
              (func3 == F3_LBU) || (func3 == F3_LHU);
    end
    return legal;
  endfunction

endpackage

// File: rtl/lsu_align_unit_if.sv
// Bundle of the core-side request/response handshake and the word-memory
// port. The unit uses the slave view; the core/memory side uses master.
interface lsu_align_unit_if #(
  parameter int ADDR_W = 32
);

  logic              req_valid;
  logic              req_ready;
  logic              req_store;
  logic [2:0]        req_func3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;

  logic              mem_rd_en;
  logic              mem_wr_en;
  logic [ADDR_W-3:0] mem_waddr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_store, req_func3, req_addr, req_wdata, mem_rdata,
    input  req_ready, mem_rd_en, mem_wr_en, mem_waddr, mem_be, mem_wdata,
           resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_store, req_func3, req_addr, req_wdata, mem_rdata,
    output req_ready, mem_rd_en, mem_wr_en, mem_waddr, mem_be, mem_wdata,
           resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/lsu_align_unit_load_extend.sv
// Load-data extractor: takes the two raw words of an access ({hi,lo}),
// shifts the addressed bytes down to bit 0 and sign/zero-extends them.
// Purely combinational so the writeback stage can reuse it as-is.
module lsu_load_extend
  import lsu_pkg::*;
(
  input  logic [63:0] i_data,
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_func3,
  output logic [31:0] o_result
);

  logic [31:0] w_shifted;

  assign w_shifted = 32'(i_data >> {i_off, 3'b000});

  // Pick the access width and apply the extension that func3 asks for
  always_comb begin
    o_result = 32'h0;
    case (i_func3)
      F3_LB:   o_result = {{24{w_shifted[7]}}, w_shifted[7:0]};
      F3_LH:   o_result = {{16{w_shifted[15]}}, w_shifted[15:0]};
      F3_LW:   o_result = w_shifted;
      F3_LBU:  o_result = {24'h0, w_shifted[7:0]};
      F3_LHU:  o_result = {16'h0, w_shifted[15:0]};
      default: o_result = 32'h0;
    endcase
  end

endmodule

// File: rtl/lsu_align_unit.sv
// Load/store alignment unit. Turns one byte-addressed load/store into one
// or two aligned word accesses with byte enables, merges and extends load
// data, and holds the core off via req_ready until the response pulse.
module lsu_align_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  lsu_align_unit_if.slave bus
);

  lsu_state_e        r_state;
  logic              r_store;
  logic [2:0]        r_func3;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [2:0]        r_size;
  logic              r_split;
  logic [31:0]       r_lo;
  logic [31:0]       r_resp_rdata;
  logic              r_resp_err;

  logic [2:0]        w_size;
  logic              w_legal;
  logic [3:0]        w_span;
  logic              w_split;
  logic [7:0]        w_mask8;
  logic [7:0]        w_be8;
  logic [63:0]       w_wd64;
  logic [ADDR_W-3:0] w_waddr0;
  logic [ADDR_W-3:0] w_waddr1;
  logic [63:0]       w_merged;
  logic [31:0]       w_ext;
  logic              w_rd_en;
  logic              w_wr_en;
  logic [ADDR_W-3:0] w_waddr;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata;

  // Request decode, only consumed on the accept edge
  assign w_size  = size_of(bus.req_func3);
  assign w_legal = is_legal(bus.req_store, bus.req_func3);
  assign w_span  = {2'b00, bus.req_addr[1:0]} + {1'b0, w_size};
  assign w_split = (w_span > 4'd4);

  // Byte-count to contiguous enable mask
  always_comb begin
    w_mask8 = 8'h0F;
    case (r_size)
      3'd1:    w_mask8 = 8'h01;
      3'd2:    w_mask8 = 8'h03;
      default: w_mask8 = 8'h0F;
    endcase
  end

  // Lane placement across the two-word window, from registered state only
  assign w_be8    = w_mask8 << r_addr[1:0];
  assign w_wd64   = {32'h0, r_wdata} << {r_addr[1:0], 3'b000};
  assign w_waddr0 = r_addr[ADDR_W-1:2];
  assign w_waddr1 = w_waddr0 + {{(ADDR_W-3){1'b0}}, 1'b1};

  // The upper word is fed straight from the bus in ACC1, and treated as
  // zero when the access stays inside one word.
  assign w_merged = (r_state == ACC1) ? {bus.mem_rdata, r_lo}
                                      : {32'h0, bus.mem_rdata};

  lsu_load_extend u_load_extend (
    .i_data   (w_merged),
    .i_off    (r_addr[1:0]),
    .i_func3  (r_func3),
    .o_result (w_ext)
  );

  // Sequencer: accept, one or two word accesses, then a single response cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_store      <= 1'b0;
      r_func3      <= 3'b000;
      r_addr       <= '0;
      r_wdata      <= 32'h0;
      r_size       <= 3'd0;
      r_split      <= 1'b0;
      r_lo         <= 32'h0;
      r_resp_rdata <= 32'h0;
      r_resp_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.req_valid) begin
            r_store <= bus.req_store;
            r_func3 <= bus.req_func3;
            r_addr  <= bus.req_addr;
            r_wdata <= bus.req_wdata;
            r_size  <= w_size;
            r_split <= w_split;
            r_lo    <= 32'h0;
            if (!w_legal) begin
              r_resp_err   <= 1'b1;
              r_resp_rdata <= 32'h0;
              r_state      <= RESP;
            end else begin
              r_state <= ACC0;
            end
          end
        end
        ACC0: begin
          if (!r_store) begin
            r_lo <= bus.mem_rdata;
          end
          if (r_split) begin
            r_state <= ACC1;
          end else begin
            r_resp_rdata <= r_store ? 32'h0 : w_ext;
            r_resp_err   <= 1'b0;
            r_state      <= RESP;
          end
        end
        ACC1: begin
          r_resp_rdata <= r_store ? 32'h0 : w_ext;
          r_resp_err   <= 1'b0;
          r_state      <= RESP;
        end
        RESP: begin
          r_resp_rdata <= 32'h0;
          r_resp_err   <= 1'b0;
          r_state      <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Memory port decode: strobes and lanes live only in the access states
  always_comb begin
    w_rd_en = 1'b0;
    w_wr_en = 1'b0;
    w_waddr = '0;
    w_be    = 4'h0;
    w_wdata = 32'h0;
    case (r_state)
      ACC0: begin
        w_rd_en = !r_store;
        w_wr_en = r_store;
        w_waddr = w_waddr0;
        w_be    = w_be8[3:0];
        w_wdata = w_wd64[31:0];
      end
      ACC1: begin
        w_rd_en = !r_store;
        w_wr_en = r_store;
        w_waddr = w_waddr1;
        w_be    = w_be8[7:4];
        w_wdata = w_wd64[63:32];
      end
      default: begin
        w_rd_en = 1'b0;
      end
    endcase
  end

  assign bus.req_ready  = (r_state == IDLE);
  assign bus.resp_valid = (r_state == RESP);
  assign bus.resp_rdata = r_resp_rdata;
  assign bus.resp_err   = r_resp_err;
  assign bus.mem_rd_en  = w_rd_en;
  assign bus.mem_wr_en  = w_wr_en;
  assign bus.mem_waddr  = w_waddr;
  assign bus.mem_be     = w_be;
  assign bus.mem_wdata  = w_wdata;

endmodule

// File: tb/tb_lsu_align_unit.sv
// Scoreboard bench for lsu_align_unit: a byte-level reference model
// predicts every memory access and every response; independent monitors
// compare what the unit actually presents.
module tb_lsu_align_unit;
  import lsu_pkg::*;

  typedef struct {
    logic        isWrite;
    logic [29:0] waddr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          cyc;
  } access_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } resp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cycle = 0;
  int   nChecks = 0;
  int   nFail = 0;

  access_t accQ[$];
  resp_t   respQ[$];
  access_t accE;
  resp_t   respE;

  logic [31:0] envMem [256];
  logic [31:0] refMem [256];

  always #5 clk = ~clk;

  lsu_align_unit_if #(.ADDR_W(32)) bus ();

  lsu_align_unit #(.ADDR_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Cycle stamp used to check access and response latency
  always @(posedge clk) cycle <= cycle + 1;

  // Word memory model: combinational-style read data for the current address
  initial bus.mem_rdata = 32'h0;
  always begin
    @(posedge clk);
    #1;
    bus.mem_rdata = envMem[bus.mem_waddr[7:0]];
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Memory-side monitor: every strobe must match the next predicted access
  always @(negedge clk) begin
    if (bus.mem_rd_en || bus.mem_wr_en) begin
      if (accQ.size() == 0) begin
        nChecks++;
        nFail++;
        $display("[TB] FAIL unexpected_strobe: got rd=%0b wr=%0b waddr=0x%08h, want no access",
                 bus.mem_rd_en, bus.mem_wr_en, bus.mem_waddr);
      end else begin
        accE = accQ.pop_front();
        checkOutput("acc.rd_en", 32'(bus.mem_rd_en), 32'(!accE.isWrite));
        checkOutput("acc.wr_en", 32'(bus.mem_wr_en), 32'(accE.isWrite));
        checkOutput("acc.waddr", 32'(bus.mem_waddr), 32'(accE.waddr));
        checkOutput("acc.be", 32'(bus.mem_be), 32'(accE.be));
        checkOutput("acc.cycle", 32'(cycle), 32'(accE.cyc));
        if (accE.isWrite) begin
          checkOutput("acc.wdata", bus.mem_wdata, accE.wdata);
        end
      end
      if (bus.mem_wr_en) begin
        for (int l = 0; l < 4; l++) begin
          if (bus.mem_be[l]) envMem[bus.mem_waddr[7:0]][8*l +: 8] = bus.mem_wdata[8*l +: 8];
        end
      end
    end else begin
      checkOutput("idle.be", 32'(bus.mem_be), 32'h0);
      checkOutput("idle.wdata", bus.mem_wdata, 32'h0);
    end
  end

  // Core-side monitor: each response pulse must match the next prediction
  always @(negedge clk) begin
    if (bus.resp_valid) begin
      checkOutput("resp.ready_low", 32'(bus.req_ready), 32'h0);
      if (respQ.size() == 0) begin
        nChecks++;
        nFail++;
        $display("[TB] FAIL unexpected_resp: got rdata=0x%08h err=%0b, want no response",
                 bus.resp_rdata, bus.resp_err);
      end else begin
        respE = respQ.pop_front();
        checkOutput("resp.rdata", bus.resp_rdata, respE.rdata);
        checkOutput("resp.err", 32'(bus.resp_err), 32'(respE.err));
        checkOutput("resp.cycle", 32'(cycle), 32'(respE.cyc));
      end
    end
  end

  // Reference model: works byte by byte over the flat address space.
  // n is the cycle stamp seen right after the accept edge.
  task automatic computeExpect(input logic store, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata, input int n, input logic abortAfterAcc0);
    int          size;
    int          off;
    logic        legal;
    logic        signExt;
    logic        split;
    logic [3:0]  be [2];
    logic [31:0] wd [2];
    logic [63:0] val;
    logic [31:0] ba;
    access_t     a;
    resp_t       r;

    legal = store ? (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010)
                  : (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010 || f3 == 3'b100 || f3 == 3'b101);
    if (!legal) begin
      r.rdata = 32'h0;
      r.err   = 1'b1;
      r.cyc   = n;
      respQ.push_back(r);
      return;
    end
    case (f3)
      3'b000, 3'b100: size = 1;
      3'b001, 3'b101: size = 2;
      default:        size = 4;
    endcase
    signExt = !store && (f3 == 3'b000 || f3 == 3'b001);
    off = int'(addr[1:0]);
    be[0] = 4'h0;
    be[1] = 4'h0;
    wd[0] = 32'h0;
    wd[1] = 32'h0;
    for (int p = 0; p < 8; p++) begin
      if (p >= off && p < off + size) be[p/4][p%4] = 1'b1;
      if (p - off >= 0 && p - off < 4) wd[p/4][8*(p%4) +: 8] = wdata[8*(p-off) +: 8];
    end
    split = (be[1] != 4'h0);
    for (int k = 0; k < 2; k++) begin
      if (k == 0 || (split && !abortAfterAcc0)) begin
        ba = addr + 32'(4 * k);
        a.isWrite = store;
        a.waddr   = ba[31:2];
        a.be      = be[k];
        a.wdata   = wd[k];
        a.cyc     = n + k;
        accQ.push_back(a);
      end
    end
    val = 64'h0;
    for (int i = 0; i < size; i++) begin
      ba = addr + 32'(i);
      if (store) begin
        if (!abortAfterAcc0 || ba[31:2] == addr[31:2])
          refMem[ba[9:2]][8*ba[1:0] +: 8] = wdata[8*i +: 8];
      end else begin
        val[8*i +: 8] = refMem[ba[9:2]][8*ba[1:0] +: 8];
      end
    end
    if (signExt && val[8*size-1]) val = val | (~64'h0 << (8 * size));
    if (!abortAfterAcc0) begin
      r.rdata = store ? 32'h0 : val[31:0];
      r.err   = 1'b0;
      r.cyc   = split ? n + 2 : n + 1;
      respQ.push_back(r);
    end
  endtask

  task automatic setWord(input int idx, input logic [31:0] v);
    envMem[idx] = v;
    refMem[idx] = v;
  endtask

  // Waits (bounded) for req_ready, presents one request for one accept edge
  task automatic applyStimulus(input logic store, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic abortAfterAcc0);
    int waitCnt;
    int n;
    waitCnt = 0;
    while (bus.req_ready !== 1'b1 && waitCnt < 20) begin
      @(posedge clk);
      #2;
      waitCnt++;
    end
    if (bus.req_ready !== 1'b1) begin
      nChecks++;
      nFail++;
      $display("[TB] FAIL ready_timeout: got req_ready=%0b, want 1 within 20 cycles", bus.req_ready);
      return;
    end
    bus.req_valid = 1'b1;
    bus.req_store = store;
    bus.req_func3 = f3;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    @(posedge clk);
    #1;
    n = cycle;
    bus.req_valid = 1'b0;
    bus.req_store = 1'($urandom);
    bus.req_func3 = 3'($urandom);
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;
    computeExpect(store, f3, addr, wdata, n, abortAfterAcc0);
  endtask

  // After a reset edge: ready high, every other output low
  task automatic checkIdleOutputs(input string tag);
    @(negedge clk);
    checkOutput({tag, ".req_ready"}, 32'(bus.req_ready), 32'h1);
    checkOutput({tag, ".rd_en"}, 32'(bus.mem_rd_en), 32'h0);
    checkOutput({tag, ".wr_en"}, 32'(bus.mem_wr_en), 32'h0);
    checkOutput({tag, ".waddr"}, 32'(bus.mem_waddr), 32'h0);
    checkOutput({tag, ".be"}, 32'(bus.mem_be), 32'h0);
    checkOutput({tag, ".wdata"}, bus.mem_wdata, 32'h0);
    checkOutput({tag, ".resp_valid"}, 32'(bus.resp_valid), 32'h0);
    checkOutput({tag, ".resp_rdata"}, bus.resp_rdata, 32'h0);
    checkOutput({tag, ".resp_err"}, 32'(bus.resp_err), 32'h0);
    @(posedge clk);
    #2;
  endtask

  // Hard stop in case the design wedges somewhere the bounded waits miss
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence: directed cases from the plan, then randomized traffic
  initial begin
    bus.req_valid = 1'b0;
    bus.req_store = 1'b0;
    bus.req_func3 = 3'b000;
    bus.req_addr  = 32'h0;
    bus.req_wdata = 32'h0;
    for (int i = 0; i < 256; i++) setWord(i, $urandom);

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checkIdleOutputs("reset");
    rst_n = 1'b1;

    setWord(4, 32'hDEADBEEF);
    applyStimulus(1'b0, F3_LW, 32'h0000_0010, 32'h0, 1'b0);

    setWord(4, 32'h80123456);
    setWord(5, 32'hABCDEF7F);
    applyStimulus(1'b0, F3_LH, 32'h0000_0013, 32'h0, 1'b0);
    applyStimulus(1'b0, F3_LHU, 32'h0000_0013, 32'h0, 1'b0);

    applyStimulus(1'b1, F3_SW, 32'h0000_0006, 32'h11223344, 1'b0);
    applyStimulus(1'b0, F3_LW, 32'h0000_0006, 32'h0, 1'b0);

    setWord(0, 32'h0000F000);
    applyStimulus(1'b0, F3_LB, 32'h0000_0001, 32'h0, 1'b0);
    applyStimulus(1'b0, F3_LBU, 32'h0000_0001, 32'h0, 1'b0);

    applyStimulus(1'b1, 3'b100, 32'h0000_0020, 32'hCAFEF00D, 1'b0);
    applyStimulus(1'b0, 3'b111, 32'h0000_0024, 32'h0, 1'b0);

    applyStimulus(1'b0, F3_LW, 32'hFFFF_FFFE, 32'h0, 1'b0);
    applyStimulus(1'b1, F3_SH, 32'hFFFF_FFFF, 32'h0000A55A, 1'b0);
    applyStimulus(1'b0, F3_LHU, 32'hFFFF_FFFF, 32'h0, 1'b0);

    applyStimulus(1'b1, F3_SW, 32'h0000_0006, 32'h11223344, 1'b1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checkIdleOutputs("abort");
    applyStimulus(1'b0, F3_LW, 32'h0000_0010, 32'h0, 1'b0);
    applyStimulus(1'b0, F3_LW, 32'h0000_0008, 32'h0, 1'b0);

    for (int t = 0; t < 150; t++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #2;
      end
      applyStimulus(1'($urandom), 3'($urandom), $urandom, $urandom, 1'b0);
    end

    repeat (8) @(posedge clk);
    #2;
    checkOutput("accQ.drained", 32'(accQ.size()), 32'h0);
    checkOutput("respQ.drained", 32'(respQ.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/lsu_align_unit.md
# lsu_align_unit

Load/store alignment unit between the core's execute stage and the word-organised data memory. It accepts one load or store request at a time and converts it into one or two aligned 32-bit word accesses with byte enables. Misaligned halfword and word accesses are split across two consecutive words, and read data is merged, shifted and sign- or zero-extended per `func3`. It stalls the core through a ready/valid handshake until the response is delivered.

## Interface
Parameters:
- `ADDR_W`, 32: byte-address width; the word address is `ADDR_W-2` bits.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept; high only in IDLE.
- `req_store` in 1: 1 = store, 0 = load.
- `req_func3` in 3: RISC-V width code. 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores use 000/001/010.
- `req_addr` in ADDR_W: byte address.
- `req_wdata` in 32: store data, right-aligned.
- `mem_rd_en` out 1: word read strobe.
- `mem_wr_en` out 1: word write strobe.
- `mem_waddr` out ADDR_W-2: word address.
- `mem_be` out 4: byte enables; bit i covers byte lane [8i+7:8i].
- `mem_wdata` out 32: lane-positioned write data.
- `mem_rdata` in 32: combinational read data for `mem_waddr`, valid in the same cycle.
- `resp_valid` out 1: one-cycle response pulse.
- `resp_rdata` out 32: extended load result; 0 for stores and errors.
- `resp_err` out 1: illegal `func3` for the access type.

## Operation
- FSM states: IDLE, ACC0, ACC1, RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`, register store flag, func3, addr, wdata, and compute `off`=addr[1:0] and size (1, 2 or 4 bytes).
  - `split` = (off + size > 4).
  - Illegal func3: load with 011/110/111, or store with anything except 000/001/010. Go straight to RESP with `resp_err`=1 and no memory access. Otherwise go to ACC0.
- Lane math: 8-bit enable vector `be8` = ((1<<size)-1) << off; 64-bit `wd64` = zero-extended wdata << (8·off).
- ACC0:
  - `mem_waddr`=addr[ADDR_W-1:2], `mem_be`=be8[3:0], `mem_wdata`=wd64[31:0].
  - Load asserts `mem_rd_en` and captures `mem_rdata` into `lo`. Store asserts `mem_wr_en`.
  - Next state: ACC1 if `split`, else RESP.
- ACC1:
  - `mem_waddr`=ACC0 word address + 1, wrapping from all-ones to 0.
  - `mem_be`=be8[7:4], `mem_wdata`=wd64[63:32].
  - Load captures `mem_rdata` into `hi`. Next state: RESP.
- RESP:
  - `resp_valid`=1 for exactly one cycle, then IDLE.
  - Load result: `m` = ({hi,lo} >> 8·off)[size·8-1:0]. Sign-extend for LB/LH; zero-extend for LBU/LHU/LW.
  - `hi` is treated as 0 when not split.
- Enables and lane outputs: `mem_rd_en`, `mem_wr_en`, `mem_be` and `mem_wdata` are 0 in IDLE and RESP. `mem_be` bits outside the accessed bytes are always 0.
- Request inputs are ignored outside IDLE; a new request is never accepted in the RESP cycle.

## Timing
- Reset: when `rst_n`=0 at a clock edge, the state becomes IDLE and all captured registers clear.
  - Outputs after reset: `req_ready`=1 and all other outputs 0.
  - Reset during ACC0/ACC1 aborts the access. No further memory strobe is issued; a store half already written stays written.
- Latency from accept edge T:
  - Aligned: ACC0 at T+1, `resp_valid` at T+2.
  - Split: ACC0 T+1, ACC1 T+2, `resp_valid` T+3.
  - Illegal: `resp_valid` at T+1.
- Throughput: one request per 3 cycles aligned, 4 cycles split, 2 cycles illegal.
- Registered outputs: `resp_rdata` and `resp_err` are registered; `mem_*` outputs are decoded from state and registers only, with no combinational path from `req_*`.

## Structure
- Shared package `lsu_pkg`:
  - `func3` width-code localparams (LB, LH, LW, LBU, LHU, SB, SH, SW).
  - `lsu_state_e` enum.
  - `size_of(func3)` function.
- Natural sub-module `lsu_load_extend`, combinational: {hi,lo}, off, func3 in; 32-bit result out. Instantiated once, and reusable by the writeback stage.

## Test plan
- **Aligned LW**: addr 0x0000_0010, memory word 4 = 0xDEADBEEF.
  - ACC0: one `mem_rd_en` at waddr 4, be 1111.
  - `resp_rdata`=0xDEADBEEF at T+2.
- **Misaligned LH**: addr 0x0000_0013, word 4 = 0x80xxxxxx, word 5 = 0xxxxxxx7F.
  - Reads at waddr 4 (be 1000) then waddr 5 (be 0001).
  - `resp_rdata`=0x00007F80 at T+3. LHU gives the same value.
- **Misaligned SW**: addr 0x0000_0006, wdata 0x11223344.
  - waddr 1, be 1100, wdata 0x33440000.
  - Then waddr 2, be 0011, wdata 0x00001122.
  - `resp_rdata`=0.
- **Sign/zero extension**: LB at addr 0x1 with word 0 = 0x0000_F000.
  - LB → 0xFFFFFFF0; LBU → 0x000000F0. Neither splits.
- **Illegal and wrap**:
  - Store with func3 100: no memory strobes, `resp_err`=1 at T+1.
  - LW at addr 0xFFFF_FFFE: second access at waddr 0.
- **Reset mid-split**: `rst_n`=0 during ACC0 of a split SW.
  - No ACC1 write occurs.
  - Next cycle: `req_ready`=1, all other outputs 0.
  - A following aligned LW completes normally.
